lc3_datapath_mem: RTL and testbench
===================================

// Module: lc3_datapath_mem
// PURPOSE
//  Parametrised LC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder, NZP, BEN.
//  Successor of the fixed 16-bit datapath, generalised in data width.
//  Adds an internal memory-access sequencer: req/ack handshake with wait states and timeout,
//  in place of a raw MIO_EN mux. Sits between the control FSM (drives LD_*/Gate*/mux selects)
//  and the memory/IO subsystem.
// PARAMETERS
//  DATA_W      16   datapath/bus width; legal values >=16; IR fields use bits [15:0]
//  PC_RESET    0    PC value after reset (DATA_W bits)
//  MEM_TIMEOUT 15   max cycles waiting for mem_ack; legal values >=1
// PORTS
//  Clk        in   1       clock, rising edge
//  Reset      in   1       asynchronous, active-low reset
//  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN  in 1 each  register load enables
//  GatePC, GateMDR, GateALU, GateMARMUX  in 1 each  bus drivers (one-hot)
//  PCMUX      in   2       0:PC+1 1:bus 2:adder 3:hold
//  ADDR2MUX   in   2       0:zero 1:sext(IR[5:0]) 2:sext(IR[8:0]) 3:sext(IR[10:0])
//  ADDR1MUX   in   1       0:PC 1:SR1
//  DRMUX      in   1       0:IR[11:9] 1:R7
//  SR1MUX     in   1       0:IR[11:9] 1:IR[8:6]
//  SR2MUX     in   1       0:SR2=IR[2:0] 1:sext(IR[4:0])
//  ALUK       in   2       0:ADD 1:AND 2:NOT A 3:PASS A
//  MEM_RD, MEM_WR  in 1    one-cycle start pulses to the memory sequencer
//  mem_req    out  1       memory request
//  mem_we     out  1       1=write, 0=read; valid while mem_req=1
//  mem_addr   out  DATA_W  address latched from MAR at start
//  mem_wdata  out  DATA_W  data latched from MDR at start
//  mem_rdata  in   DATA_W  read data, sampled when mem_ack=1
//  mem_ack    in   1       memory completion
//  mem_busy   out  1       sequencer not IDLE
//  mem_done   out  1       1-cycle pulse: access completed
//  mem_err    out  1       1-cycle pulse: timeout or illegal start
//  bus_conflict out 1      more than one Gate* asserted (combinational)
//  PC_out, IR_out, MAR_out, MDR_out  out DATA_W  register contents
//  nzp        out  3       condition codes {n,z,p}
//  BEN        out  1       branch enable
// BEHAVIOUR
//  Reset (Reset=0, async): PC=PC_RESET; IR/MAR/MDR/regfile=0; nzp=3'b010; BEN=0; FSM=IDLE;
//    mem_req/mem_we/mem_done/mem_err=0; mem_addr/mem_wdata=0.
//  Bus: value of the single asserted Gate* source. No gate -> 0. >1 gate -> bus=0, bus_conflict=1.
//  Sign extension is combinational from current IR to DATA_W; no pipeline delay.
//  Adder = ADDR1MUX + ADDR2MUX, mod 2^DATA_W. ALU ADD wraps mod 2^DATA_W.
//  Regfile: 2 async read ports, 1 sync write at Clk on LD_REG. Read-during-write returns the old value.
//  NZP on LD_CC from bus: n=bus[DATA_W-1]; z=(bus==0); p=otherwise. Exactly one bit set.
//  BEN on LD_BEN <= |(IR[11:9] & nzp), using nzp before any same-cycle LD_CC update.
//  PCMUX=3 with LD_PC=1 leaves PC unchanged.
//  Sequencer states: IDLE -> RD_WAIT | WR_WAIT -> DONE -> IDLE; timeout path returns to IDLE.
//   IDLE: MEM_RD xor MEM_WR: latch mem_addr<=MAR, mem_wdata<=MDR, mem_we<=MEM_WR, mem_req<=1,
//     clear counter, go to RD_WAIT/WR_WAIT. MEM_RD&MEM_WR together: mem_err pulse, stay IDLE.
//   *_WAIT: mem_req held. On mem_ack: mem_req<=0. A read loads MDR<=mem_rdata.
//     Next state is DONE. Counter increments each cycle without mem_ack.
//     Counter reaching MEM_TIMEOUT: mem_req<=0, mem_err pulse, MDR unchanged, back to IDLE.
//   DONE: mem_done=1 for exactly one cycle, then IDLE.
//   Minimum read latency: start pulse at cycle 0, ack at 1, MDR valid and mem_done at 2.
//  MEM_RD/MEM_WR while busy: ignored, no error.
//  LD_MAR/LD_MDR while busy: registers update; the in-flight access uses the latched values.
//  RD_WAIT ack with LD_MDR in the same cycle: memory data wins.
//  mem_ack outside *_WAIT: ignored.
//  Reset mid-access: mem_req drops immediately; FSM goes to IDLE; no mem_done.
// TESTING
//  1 Reset, DATA_W=16: PC=0, nzp=010, mem_req=0. Pulse PCMUX=0 with LD_PC x3 -> PC=3.
//  2 IR=16'h1262 (ADD R1,R1,#2), R1=16'h7FFF, GateALU, LD_REG, LD_CC -> R1=16'h8001, nzp=100.
//  3 MAR=16'h3000, MEM_RD, ack after 3 wait cycles with rdata=16'hBEEF -> MDR=16'hBEEF, mem_done 1 cycle.
//  4 MEM_WR with MDR=16'h1234, no ack, MEM_TIMEOUT=15 -> mem_err after 15 cycles; MDR unchanged.
//  5 GatePC and GateMDR together -> bus_conflict=1, LD_IR loads 0. MEM_RD+MEM_WR in same cycle -> mem_err.
//  6 DATA_W=32, IR=16'h0FFE (BRnzp #-2), PC=32'h10, ADDR2MUX=2, PCMUX=2 -> PC=32'hE, BEN=1 after LD_BEN.

Source files
------------

// File: rtl/lc3_datapath_mem.sv
// LC-3 datapath (PC/IR/MAR/MDR, regfile, ALU, address adder, NZP, BEN) with a
// req/ack memory-access sequencer that supports wait states and a timeout.
module lc3_datapath_mem #(
    parameter int unsigned       DATA_W      = 16,
    parameter logic [DATA_W-1:0] PC_RESET    = '0,
    parameter int unsigned       MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              LD_IR,
    input  logic              LD_PC,
    input  logic              LD_REG,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              GatePC,
    input  logic              GateMDR,
    input  logic              GateALU,
    input  logic              GateMARMUX,
    input  logic [1:0]        PCMUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic              ADDR1MUX,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    input  logic              SR2MUX,
    input  logic [1:0]        ALUK,
    input  logic              MEM_RD,
    input  logic              MEM_WR,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] IR_out,
    output logic [DATA_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MDR_out,
    output logic [2:0]        nzp,
    output logic              BEN
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned NREG  = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } seq_state_e;

    seq_state_e        state;
    logic [CNT_W-1:0]  wait_cnt;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] regfile [NREG];
    logic [2:0]        nzp_q;
    logic              ben_q;

    logic [2:0]        gate_cnt;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] sext5;
    logic [DATA_W-1:0] sext6;
    logic [DATA_W-1:0] sext9;
    logic [DATA_W-1:0] sext11;
    logic [2:0]        sr1_sel;
    logic [2:0]        dr_sel;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] sr2_val;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] adder_out;
    logic [DATA_W-1:0] pc_next;
    logic [2:0]        nzp_next;
    logic              rd_load;

    // Immediate fields, sign-extended straight from the current IR
    assign sext5  = {{(DATA_W-5){ir_q[4]}},   ir_q[4:0]};
    assign sext6  = {{(DATA_W-6){ir_q[5]}},   ir_q[5:0]};
    assign sext9  = {{(DATA_W-9){ir_q[8]}},   ir_q[8:0]};
    assign sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

    assign sr1_sel = SR1MUX ? ir_q[8:6] : ir_q[11:9];
    assign dr_sel  = DRMUX ? 3'd7 : ir_q[11:9];
    assign sr1_val = regfile[sr1_sel];
    assign sr2_val = regfile[ir_q[2:0]];
    assign alu_b   = SR2MUX ? sext5 : sr2_val;

    always_comb begin
        alu_out = sr1_val;
        case (ALUK)
            2'd0:    alu_out = sr1_val + alu_b;
            2'd1:    alu_out = sr1_val & alu_b;
            2'd2:    alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    always_comb begin
        addr2 = '0;
        case (ADDR2MUX)
            2'd0:    addr2 = '0;
            2'd1:    addr2 = sext6;
            2'd2:    addr2 = sext9;
            default: addr2 = sext11;
        endcase
    end

    assign addr1     = ADDR1MUX ? sr1_val : pc_q;
    assign adder_out = addr1 + addr2;

    // Bus is forced to zero when no driver or several drivers are enabled
    assign gate_cnt     = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);
    assign bus_conflict = (gate_cnt > 3'd1);

    always_comb begin
        bus = '0;
        if (gate_cnt == 3'd1) begin
            if (GatePC)       bus = pc_q;
            else if (GateMDR) bus = mdr_q;
            else if (GateALU) bus = alu_out;
            else              bus = adder_out;
        end
    end

    always_comb begin
        pc_next = pc_q;
        case (PCMUX)
            2'd0:    pc_next = pc_q + DATA_W'(1);
            2'd1:    pc_next = bus;
            2'd2:    pc_next = adder_out;
            default: pc_next = pc_q;
        endcase
    end

    always_comb begin
        nzp_next = 3'b001;
        if (bus[DATA_W-1])   nzp_next = 3'b100;
        else if (bus == '0)  nzp_next = 3'b010;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= '0;
            mar_q <= '0;
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            if (LD_PC)  pc_q  <= pc_next;
            if (LD_IR)  ir_q  <= bus;
            if (LD_MAR) mar_q <= bus;
            if (LD_CC)  nzp_q <= nzp_next;
            if (LD_BEN) ben_q <= |(ir_q[11:9] & nzp_q);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(NREG); i++) regfile[i] <= '0;
        end else if (LD_REG) begin
            regfile[dr_sel] <= bus;
        end
    end

    // Read data returning from memory takes priority over a bus load of MDR
    assign rd_load = (state == S_RD_WAIT) && mem_ack;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mdr_q <= '0;
        end else if (rd_load) begin
            mdr_q <= mem_rdata;
        end else if (LD_MDR) begin
            mdr_q <= bus;
        end
    end

    // Memory-access sequencer; address and write data are captured at start
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_busy  <= 1'b0;
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MEM_RD ^ MEM_WR) begin
                        mem_addr  <= mar_q;
                        mem_wdata <= mdr_q;
                        mem_we    <= MEM_WR;
                        mem_req   <= 1'b1;
                        mem_busy  <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= MEM_RD ? S_RD_WAIT : S_WR_WAIT;
                    end else if (MEM_RD && MEM_WR) begin
                        mem_err <= 1'b1;
                    end
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        mem_req  <= 1'b0;
                        mem_err  <= 1'b1;
                        mem_busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    mem_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign PC_out  = pc_q;
    assign IR_out  = ir_q;
    assign MAR_out = mar_q;
    assign MDR_out = mdr_q;
    assign nzp     = nzp_q;
    assign BEN     = ben_q;

endmodule

// File: tb/tb_lc3_datapath_mem.sv
// Bench for lc3_datapath_mem: a 16-bit and a 32-bit instance share control
// stimulus and are both checked every cycle against a behavioural model.
module tb_lc3_datapath_mem;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic rst;
        logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
        logic g_pc, g_mdr, g_alu, g_marmux;
        logic [1:0] pcmux, addr2mux;
        logic addr1mux, drmux, sr1mux, sr2mux;
        logic [1:0] aluk;
        logic rd, wr, ack;
        logic [31:0] rdata;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc, ir, mar, mdr, addr, wdata;
        logic [2:0]  nzp;
        logic        ben, req, we, busy, done, err, bc;
    } obs_t;

    logic Reset, LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MEM_RD, MEM_WR, mem_ack;
    logic [31:0] rdata32;

    logic        req_a, we_a, busy_a, done_a, err_a, bc_a, ben_a;
    logic [15:0] addr_a, wdata_a, pc_a, ir_a, mar_a, mdr_a;
    logic [2:0]  nzp_a;
    logic        req_b, we_b, busy_b, done_b, err_b, bc_b, ben_b;
    logic [31:0] addr_b, wdata_b, pc_b, ir_b, mar_b, mdr_b;
    logic [2:0]  nzp_b;

    lc3_datapath_mem #(.DATA_W(16), .PC_RESET(16'h0000), .MEM_TIMEOUT(15)) u_dut16 (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_rdata(rdata32[15:0]), .mem_ack(mem_ack), .mem_busy(busy_a),
        .mem_done(done_a), .mem_err(err_a), .bus_conflict(bc_a),
        .PC_out(pc_a), .IR_out(ir_a), .MAR_out(mar_a), .MDR_out(mdr_a),
        .nzp(nzp_a), .BEN(ben_a)
    );

    lc3_datapath_mem #(.DATA_W(32), .PC_RESET(32'h0000_0100), .MEM_TIMEOUT(4)) u_dut32 (
        .Clk(Clk), .Reset(Reset),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ALUK(ALUK), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata32), .mem_ack(mem_ack), .mem_busy(busy_b),
        .mem_done(done_b), .mem_err(err_b), .bus_conflict(bc_b),
        .PC_out(pc_b), .IR_out(ir_b), .MAR_out(mar_b), .MDR_out(mdr_b),
        .nzp(nzp_b), .BEN(ben_b)
    );

    obs_t o [2];
    always_comb begin
        o[0].pc = 32'(pc_a);   o[0].ir = 32'(ir_a);   o[0].mar = 32'(mar_a);
        o[0].mdr = 32'(mdr_a); o[0].addr = 32'(addr_a); o[0].wdata = 32'(wdata_a);
        o[0].nzp = nzp_a; o[0].ben = ben_a; o[0].req = req_a; o[0].we = we_a;
        o[0].busy = busy_a; o[0].done = done_a; o[0].err = err_a; o[0].bc = bc_a;
        o[1].pc = pc_b;   o[1].ir = ir_b;   o[1].mar = mar_b;
        o[1].mdr = mdr_b; o[1].addr = addr_b; o[1].wdata = wdata_b;
        o[1].nzp = nzp_b; o[1].ben = ben_b; o[1].req = req_b; o[1].we = we_b;
        o[1].busy = busy_b; o[1].done = done_b; o[1].err = err_b; o[1].bc = bc_b;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic bc_last;

    // Behavioural model state; phase 0 idle, 1 read wait, 2 write wait, 3 done
    logic [31:0] m_pc [2], m_ir [2], m_mar [2], m_mdr [2], m_addr [2], m_wdata [2];
    logic [31:0] m_rf [2][8];
    logic [2:0]  m_nzp [2];
    logic        m_ben [2], m_req [2], m_we [2], m_err [2];
    int          m_phase [2], m_wait [2];

    function automatic int wd(input int d);
        return (d != 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] msk(input int d);
        return (d != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int tout(input int d);
        return (d != 0) ? 4 : 15;
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits, input int d);
        logic [31:0] mk, r;
        mk = (32'd1 << bits) - 32'd1;
        r  = v & mk;
        if (v[bits-1]) r = r | ~mk;
        return r & msk(d);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_pc[d] = (d != 0) ? 32'h100 : 32'h0;
        m_ir[d] = 0; m_mar[d] = 0; m_mdr[d] = 0; m_addr[d] = 0; m_wdata[d] = 0;
        for (int i = 0; i < 8; i++) m_rf[d][i] = 0;
        m_nzp[d] = 3'b010; m_ben[d] = 0; m_req[d] = 0; m_we[d] = 0; m_err[d] = 0;
        m_phase[d] = 0; m_wait[d] = 0;
    endtask

    task automatic model_step(input int d, input ctrl_t c);
        logic [31:0] m, bus, sr1, b, alu, a1, a2, add, new_mdr;
        int ng;
        if (!c.rst) begin
            model_reset(d);
            return;
        end
        m   = msk(d);
        ng  = int'(c.g_pc) + int'(c.g_mdr) + int'(c.g_alu) + int'(c.g_marmux);
        sr1 = m_rf[d][c.sr1mux ? m_ir[d][8:6] : m_ir[d][11:9]];
        b   = c.sr2mux ? sx(m_ir[d], 5, d) : m_rf[d][m_ir[d][2:0]];
        case (c.aluk)
            2'd0:    alu = (sr1 + b) & m;
            2'd1:    alu = sr1 & b;
            2'd2:    alu = ~sr1 & m;
            default: alu = sr1;
        endcase
        a1 = c.addr1mux ? sr1 : m_pc[d];
        case (c.addr2mux)
            2'd0:    a2 = 0;
            2'd1:    a2 = sx(m_ir[d], 6, d);
            2'd2:    a2 = sx(m_ir[d], 9, d);
            default: a2 = sx(m_ir[d], 11, d);
        endcase
        add = (a1 + a2) & m;
        bus = 0;
        if (ng == 1) bus = c.g_pc ? m_pc[d] : c.g_mdr ? m_mdr[d] : c.g_alu ? alu : add;

        new_mdr = c.ld_mdr ? bus : m_mdr[d];
        m_err[d] = 0;
        if (m_phase[d] == 0) begin
            if (c.rd != c.wr) begin
                m_addr[d] = m_mar[d]; m_wdata[d] = m_mdr[d]; m_we[d] = c.wr;
                m_req[d] = 1; m_phase[d] = c.rd ? 1 : 2; m_wait[d] = 0;
            end else if (c.rd && c.wr) begin
                m_err[d] = 1;
            end
        end else if (m_phase[d] == 3) begin
            m_phase[d] = 0;
        end else if (c.ack) begin
            m_req[d] = 0;
            if (m_phase[d] == 1) new_mdr = c.rdata & m;
            m_phase[d] = 3;
        end else begin
            m_wait[d]++;
            if (m_wait[d] == tout(d)) begin
                m_req[d] = 0; m_err[d] = 1; m_phase[d] = 0;
            end
        end

        if (c.ld_ben) m_ben[d] = |(m_ir[d][11:9] & m_nzp[d]);
        if (c.ld_cc)  m_nzp[d] = bus[wd(d)-1] ? 3'b100 : (bus == 0) ? 3'b010 : 3'b001;
        if (c.ld_reg) m_rf[d][c.drmux ? 3'd7 : m_ir[d][11:9]] = bus;
        if (c.ld_pc) begin
            case (c.pcmux)
                2'd0:    m_pc[d] = (m_pc[d] + 1) & m;
                2'd1:    m_pc[d] = bus;
                2'd2:    m_pc[d] = add;
                default: m_pc[d] = m_pc[d];
            endcase
        end
        if (c.ld_ir)  m_ir[d]  = bus;
        if (c.ld_mar) m_mar[d] = bus;
        m_mdr[d] = new_mdr;
    endtask

    task automatic check_outputs(input int d);
        chk("pc", d, o[d].pc, m_pc[d]);
        chk("ir", d, o[d].ir, m_ir[d]);
        chk("mar", d, o[d].mar, m_mar[d]);
        chk("mdr", d, o[d].mdr, m_mdr[d]);
        chk("nzp", d, 32'(o[d].nzp), 32'(m_nzp[d]));
        chk("ben", d, 32'(o[d].ben), 32'(m_ben[d]));
        chk("mem_req", d, 32'(o[d].req), 32'(m_req[d]));
        chk("mem_busy", d, 32'(o[d].busy), 32'(m_phase[d] != 0));
        chk("mem_done", d, 32'(o[d].done), 32'(m_phase[d] == 3));
        chk("mem_err", d, 32'(o[d].err), 32'(m_err[d]));
        chk("mem_addr", d, o[d].addr, m_addr[d]);
        chk("mem_wdata", d, o[d].wdata, m_wdata[d]);
        if (m_req[d]) chk("mem_we", d, 32'(o[d].we), 32'(m_we[d]));
    endtask

    task automatic drive(input ctrl_t c);
        Reset = c.rst; LD_MAR = c.ld_mar; LD_MDR = c.ld_mdr; LD_IR = c.ld_ir;
        LD_PC = c.ld_pc; LD_REG = c.ld_reg; LD_CC = c.ld_cc; LD_BEN = c.ld_ben;
        GatePC = c.g_pc; GateMDR = c.g_mdr; GateALU = c.g_alu; GateMARMUX = c.g_marmux;
        PCMUX = c.pcmux; ADDR2MUX = c.addr2mux; ADDR1MUX = c.addr1mux; DRMUX = c.drmux;
        SR1MUX = c.sr1mux; SR2MUX = c.sr2mux; ALUK = c.aluk;
        MEM_RD = c.rd; MEM_WR = c.wr; mem_ack = c.ack; rdata32 = c.rdata;
    endtask

    function automatic ctrl_t nop();
        ctrl_t c;
        c = '0;
        c.rst = 1'b1;
        return c;
    endfunction

    // One clock: drive at negedge, check combinational outputs, step model, check after edge
    task automatic cycle(input ctrl_t c);
        int ng;
        drive(c);
        #1;
        ng = int'(c.g_pc) + int'(c.g_mdr) + int'(c.g_alu) + int'(c.g_marmux);
        for (int d = 0; d < 2; d++) begin
            chk("bus_conflict", d, 32'(o[d].bc), 32'(ng > 1));
            if (!c.rst) chk("async_req_drop", d, 32'(o[d].req), 32'd0);
        end
        bc_last = o[0].bc;
        for (int d = 0; d < 2; d++) model_step(d, c);
        @(posedge Clk);
        @(negedge Clk);
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        ctrl_t c;
        c = nop(); c.rd = 1'b1; cycle(c);
        c = nop(); c.ack = 1'b1; c.rdata = v; cycle(c);
        c = nop(); cycle(c);
    endtask

    initial begin
        ctrl_t c;
        int stall;
        int r;
        c = nop(); c.rst = 1'b0;
        drive(c);
        @(negedge Clk);
        cycle(c);
        chk("t1_pc_reset", 0, o[0].pc, 32'h0);
        chk("t1_pc_reset", 1, o[1].pc, 32'h100);
        chk("t1_nzp_reset", 0, 32'(o[0].nzp), 32'h2);
        chk("t1_req_reset", 0, 32'(o[0].req), 32'h0);
        repeat (3) begin c = nop(); c.ld_pc = 1'b1; c.pcmux = 2'd0; cycle(c); end
        chk("t1_pc_inc3", 0, o[0].pc, 32'h3);

        load_mdr(32'h1262);
        c = nop(); c.g_mdr = 1'b1; c.ld_ir = 1'b1; cycle(c);
        load_mdr(32'h7FFF);
        c = nop(); c.g_mdr = 1'b1; c.ld_reg = 1'b1; cycle(c);
        c = nop(); c.g_alu = 1'b1; c.aluk = 2'd0; c.sr1mux = 1'b1; c.sr2mux = 1'b1;
        c.ld_reg = 1'b1; c.ld_cc = 1'b1; cycle(c);
        chk("t2_nzp", 0, 32'(o[0].nzp), 32'h4);
        chk("t2_nzp", 1, 32'(o[1].nzp), 32'h1);
        c = nop(); c.g_alu = 1'b1; c.aluk = 2'd3; c.sr1mux = 1'b1; c.ld_mar = 1'b1; cycle(c);
        chk("t2_r1", 0, o[0].mar, 32'h8001);
        chk("t2_r1", 1, o[1].mar, 32'h8001);

        load_mdr(32'h3000);
        c = nop(); c.g_mdr = 1'b1; c.ld_mar = 1'b1; cycle(c);
        c = nop(); c.rd = 1'b1; cycle(c);
        chk("t3_addr", 0, o[0].addr, 32'h3000);
        chk("t3_req", 0, 32'(o[0].req), 32'h1);
        repeat (3) begin c = nop(); c.rdata = 32'hDEAD; cycle(c); end
        chk("t3_still_busy", 0, 32'(o[0].busy), 32'h1);
        c = nop(); c.ack = 1'b1; c.rdata = 32'hBEEF; cycle(c);
        chk("t3_mdr", 0, o[0].mdr, 32'hBEEF);
        chk("t3_done", 0, 32'(o[0].done), 32'h1);
        c = nop(); cycle(c);
        chk("t3_done_clear", 0, 32'(o[0].done), 32'h0);

        load_mdr(32'h1234);
        c = nop(); c.wr = 1'b1; cycle(c);
        chk("t4_wdata", 0, o[0].wdata, 32'h1234);
        chk("t4_we", 0, 32'(o[0].we), 32'h1);
        repeat (14) cycle(nop());
        chk("t4_no_err_yet", 0, 32'(o[0].err), 32'h0);
        cycle(nop());
        chk("t4_err", 0, 32'(o[0].err), 32'h1);
        chk("t4_req_drop", 0, 32'(o[0].req), 32'h0);
        chk("t4_mdr_kept", 0, o[0].mdr, 32'h1234);

        c = nop(); c.g_pc = 1'b1; c.g_mdr = 1'b1; c.ld_ir = 1'b1; cycle(c);
        chk("t5_conflict", 0, 32'(bc_last), 32'h1);
        chk("t5_ir_zero", 0, o[0].ir, 32'h0);
        c = nop(); c.rd = 1'b1; c.wr = 1'b1; cycle(c);
        chk("t5_err_both", 0, 32'(o[0].err), 32'h1);
        chk("t5_idle", 0, 32'(o[0].busy), 32'h0);

        load_mdr(32'h10);
        c = nop(); c.g_mdr = 1'b1; c.ld_pc = 1'b1; c.pcmux = 2'd1; c.ld_cc = 1'b1; cycle(c);
        load_mdr(32'h0FFE);
        c = nop(); c.g_mdr = 1'b1; c.ld_ir = 1'b1; cycle(c);
        c = nop(); c.addr1mux = 1'b0; c.addr2mux = 2'd2; c.pcmux = 2'd2;
        c.ld_pc = 1'b1; c.ld_ben = 1'b1; cycle(c);
        chk("t6_pc", 1, o[1].pc, 32'hE);
        chk("t6_ben", 1, 32'(o[1].ben), 32'h1);
        chk("t6_pc", 0, o[0].pc, 32'hE);

        stall = 0;
        for (int k = 0; k < 3000; k++) begin
            c = nop();
            c.rst = ($urandom_range(0, 299) != 0);
            {c.ld_mar, c.ld_mdr, c.ld_ir, c.ld_pc, c.ld_reg, c.ld_cc, c.ld_ben} =
                7'($urandom) & 7'($urandom);
            r = $urandom_range(0, 15);
            if (r <= 2)       c.g_pc = 1'b1;
            else if (r <= 5)  c.g_mdr = 1'b1;
            else if (r <= 9)  c.g_alu = 1'b1;
            else if (r <= 12) c.g_marmux = 1'b1;
            else if (r == 14) begin c.g_pc = 1'b1; c.g_alu = 1'b1; end
            else if (r == 15) begin c.g_mdr = 1'b1; c.g_marmux = 1'b1; end
            {c.pcmux, c.addr2mux, c.addr1mux, c.drmux, c.sr1mux, c.sr2mux, c.aluk} = 10'($urandom);
            r = $urandom_range(0, 15);
            c.rd = (r == 0) || (r == 2) || (r == 3);
            c.wr = (r == 1) || (r == 2) || (r == 4);
            if (stall > 0) stall--;
            else if ($urandom_range(0, 40) == 0) stall = $urandom_range(5, 20);
            c.ack = (stall == 0) && ($urandom_range(0, 3) == 0);
            c.rdata = $urandom;
            cycle(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
